// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: default operand width and the
// splitter FSM encoding.
package adder_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } splitter_state_e;

    // Counter width able to hold 0..width inclusive.
    function automatic int countBits(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = s - a_i - borrow_i, with borrow out.
module full_subtractor_bit (
    input  logic s_i,
    input  logic a_i,
    input  logic borrow_i,
    output logic d_o,
    output logic borrow_o
);

    always_comb begin
        d_o      = s_i ^ a_i ^ borrow_i;
        borrow_o = (~s_i & a_i) | (~(s_i ^ a_i) & borrow_i);
    end

endmodule

// File: rtl/serial_sum_splitter.sv
// Bit-serial recovery of b = sum - a, one bit per clock LSB first, with
// valid/ready on both sides and a flag for results outside WIDTH bits.
module serial_sum_splitter
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             range_err
);

    localparam int CW = countBits(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

    splitter_state_e  state_q;
    logic [CW-1:0]    bitCount_q;
    logic [WIDTH:0]   sumShift_q;
    logic [WIDTH-1:0] addShift_q;
    logic [WIDTH:0]   result_q;
    logic             borrow_q;
    logic             outValid_q;
    logic [WIDTH-1:0] b_q;
    logic             rangeErr_q;

    logic             diff_d;
    logic             borrow_d;

    // The addend register shifts in zeros, so bit WIDTH of a reads as 0.
    full_subtractor_bit u_cell (
        .s_i      (sumShift_q[0]),
        .a_i      (addShift_q[0]),
        .borrow_i (borrow_q),
        .d_o      (diff_d),
        .borrow_o (borrow_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitCount_q <= '0;
            sumShift_q <= '0;
            addShift_q <= '0;
            result_q   <= '0;
            borrow_q   <= 1'b0;
            outValid_q <= 1'b0;
            b_q        <= '0;
            rangeErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sumShift_q <= sum;
                        addShift_q <= a;
                        result_q   <= '0;
                        borrow_q   <= 1'b0;
                        bitCount_q <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sumShift_q <= sumShift_q >> 1;
                    addShift_q <= addShift_q >> 1;
                    result_q   <= {diff_d, result_q[WIDTH:1]};
                    borrow_q   <= borrow_d;
                    bitCount_q <= bitCount_q + CW'(1);
                    // On the final bit, the low WIDTH result bits are already in result_q[WIDTH:1].
                    if (bitCount_q == LAST_BIT) begin
                        b_q        <= result_q[WIDTH:1];
                        rangeErr_q <= borrow_d | diff_d;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = outValid_q;
    assign b         = b_q;
    assign range_err = rangeErr_q;

endmodule

// File: tb/tb_serial_sum_splitter.sv
// Directed self-checking bench for serial_sum_splitter (WIDTH=4).
module tb_serial_sum_splitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] sum;
    logic [3:0] a;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] b;
    logic       range_err;

    int total = 0;
    int bad   = 0;
    int lat;

    serial_sum_splitter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Offers one operand pair, then counts edges until out_valid (bounded).
    // Returns at the negedge where out_valid was first seen high.
    task automatic applyStimulus(input logic [4:0] sumV, input logic [3:0] aV,
                                 input bit pulseBusy, output int latency);
        @(negedge clk);
        in_valid = 1'b1;
        sum      = sumV;
        a        = aV;
        @(posedge clk);
        latency = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && latency < 20) begin
            if (pulseBusy && latency == 1) begin
                in_valid = 1'b1;
                sum      = 5'd0;
                a        = 4'd0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sum       = 5'd31;
        a         = 4'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_b", b, 0);
        checkOutput("rst_range_err", range_err, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("[TB] basic 8-5 with backpressure");
        applyStimulus(5'd8, 4'd5, 1'b0, lat);
        checkOutput("basic_latency", lat, 5);
        checkOutput("basic_b", b, 3);
        checkOutput("basic_err", range_err, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_b", b, 3);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("done_valid_low", out_valid, 0);
        checkOutput("done_in_ready", in_ready, 1);
        checkOutput("retained_b", b, 3);

        $display("[TB] back-to-back with free consumer");
        applyStimulus(5'd16, 4'd15, 1'b0, lat);
        checkOutput("b2b1_latency", lat, 5);
        checkOutput("b2b1_b", b, 1);
        checkOutput("b2b1_err", range_err, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b1_in_ready", in_ready, 1);
        checkOutput("b2b1_valid_low", out_valid, 0);
        applyStimulus(5'd16, 4'd8, 1'b0, lat);
        checkOutput("b2b2_b", b, 8);
        checkOutput("b2b2_err", range_err, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b2_in_ready", in_ready, 1);

        $display("[TB] underflow with busy-input pulse, overflow");
        applyStimulus(5'd3, 4'd5, 1'b1, lat);
        checkOutput("under_latency", lat, 5);
        checkOutput("under_b", b, 14);
        checkOutput("under_err", range_err, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("under_in_ready", in_ready, 1);
        applyStimulus(5'd31, 4'd0, 1'b0, lat);
        checkOutput("over_b", b, 15);
        checkOutput("over_err", range_err, 1);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] reset mid-operation");
        in_valid = 1'b1;
        sum      = 5'd3;
        a        = 4'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_b", b, 0);
        checkOutput("abort_err", range_err, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        applyStimulus(5'd10, 4'd4, 1'b0, lat);
        checkOutput("fresh_latency", lat, 5);
        checkOutput("fresh_b", b, 6);
        checkOutput("fresh_err", range_err, 0);
        @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
